// File: rtl/top_level_if.sv
// Request/acknowledge handshake between a host and the Hamming/pattern engine.
interface top_level_if;
   logic req;
   logic ack;

   modport master (output req, input  ack);
   modport slave  (input  req, output ack);
endinterface

// File: rtl/top_level.sv
// Hamming SECDED encode/decode and 5-bit pattern-count engine over a private
// 256x8 memory; each accepted request runs the next of three fixed programs.

module top_level_mem (
   input  logic       clk,
   input  logic       we_i,
   input  logic [7:0] waddr_i,
   input  logic [7:0] wdata_i,
   input  logic [7:0] raddr0_i,
   input  logic [7:0] raddr1_i,
   output logic [7:0] rdata0_o,
   output logic [7:0] rdata1_o
);
   logic [7:0] core [0:255];

   always_ff @(posedge clk) begin
      if (we_i) core[waddr_i] <= wdata_i;
   end

   assign rdata0_o = core[raddr0_i];
   assign rdata1_o = core[raddr1_i];
endmodule

// state   | meaning
// IDLE    | waiting for the first request after reset
// RUN     | executing program prog_q; idx_q/phase_q track the sub-step
// DONE    | program finished, ack held high until the next request
module top_level (
   input  logic       clk,
   input  logic       reset,
   top_level_if.slave bus
);
   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

   localparam logic [7:0] PAT_ADDR = 8'd160;

   state_t     state_q, state_d;
   logic [1:0] prog_q, prog_d;
   logic [4:0] idx_q, idx_d;
   logic       phase_q, phase_d;
   logic       ack_q, ack_d;
   logic [4:0] pat_q, pat_d;
   logic [7:0] ctb_q, ctb_d;
   logic [7:0] cto_q, cto_d;
   logic [7:0] cts_q, cts_d;

   logic       mem_we;
   logic [7:0] mem_waddr, mem_wdata;
   logic [7:0] mem_ra0, mem_ra1, rd0, rd1;
   logic [7:0] word_base;
   logic [15:0] enc_w;
   logic [11:0] dec_w;
   logic [2:0] nb, nx;
   logic       finish;

   function automatic logic [3:0] parity4(input logic [11:1] d);
      logic p8, p4, p2, p1;
      p8 = ^d[11:5];
      p4 = (^d[11:8]) ^ (^d[4:2]);
      p2 = d[11] ^ d[10] ^ d[7] ^ d[6] ^ d[4] ^ d[3] ^ d[1];
      p1 = d[11] ^ d[9] ^ d[7] ^ d[5] ^ d[4] ^ d[2] ^ d[1];
      return {p8, p4, p2, p1};
   endfunction

   function automatic logic [15:0] encode(input logic [10:0] dv);
      logic [11:1] d;
      logic [3:0]  p;
      logic        p16;
      d   = dv;
      p   = parity4(d);
      p16 = (^d) ^ (^p);
      return {d[11:5], p[3], d[4:2], p[2], d[1], p[1], p[0], p16};
   endfunction

   function automatic logic [10:0] extract(input logic [15:0] w);
      return {w[15:9], w[7:5], w[3]};
   endfunction

   // Result is {dbl, d[11:1]}; a double error leaves d exactly as received.
   function automatic logic [11:0] decode(input logic [15:0] w_in);
      logic [15:0] w;
      logic [11:1] d;
      logic [3:0]  s, e;
      logic        g, dbl;
      w   = w_in;
      d   = extract(w);
      s   = parity4(d);
      e   = {w[8] ^ s[3], w[4] ^ s[2], w[2] ^ s[1], w[1] ^ s[0]};
      g   = ^w;
      dbl = 1'b0;
      if (e != 4'd0 && g) begin
         w[e] = ~w[e];
         d    = extract(w);
      end else if (e != 4'd0) begin
         dbl = 1'b1;
      end
      return {dbl, d};
   endfunction

   function automatic logic [2:0] count4(input logic [7:0] b, input logic [4:0] p);
      logic [2:0] n;
      n = 3'd0;
      for (int j = 0; j < 4; j++) begin
         if (b[j +: 5] == p) n = n + 3'd1;
      end
      return n;
   endfunction

   top_level_mem data_mem1 (
      .clk      (clk),
      .we_i     (mem_we & reset),
      .waddr_i  (mem_waddr),
      .wdata_i  (mem_wdata),
      .raddr0_i (mem_ra0),
      .raddr1_i (mem_ra1),
      .rdata0_o (rd0),
      .rdata1_o (rd1)
   );

   assign word_base = {2'b00, idx_q, 1'b0};
   assign bus.ack   = ack_q;

   // Read addresses depend on state only, keeping the datapath loop-free.
   always_comb begin
      mem_ra0 = PAT_ADDR;
      mem_ra1 = 8'd0;
      if (state_q == ST_RUN) begin
         case (prog_q)
            2'd1: begin
               mem_ra0 = word_base;
               mem_ra1 = word_base + 8'd1;
            end
            2'd2: begin
               mem_ra0 = 8'd64 + word_base;
               mem_ra1 = 8'd65 + word_base;
            end
            2'd3: begin
               mem_ra0 = 8'd128 + {3'b000, idx_q};
               mem_ra1 = 8'd127 + {3'b000, idx_q};
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      enc_w = encode({rd1[2:0], rd0});
      dec_w = decode({rd1, rd0});
      nb    = count4(rd0, pat_q);
      nx    = (idx_q != 5'd0) ? count4({rd1[3:0], rd0[7:4]}, pat_q) : 3'd0;
   end

   always_comb begin
      state_d   = state_q;
      prog_d    = prog_q;
      idx_d     = idx_q;
      phase_d   = phase_q;
      ack_d     = ack_q;
      pat_d     = pat_q;
      ctb_d     = ctb_q;
      cto_d     = cto_q;
      cts_d     = cts_q;
      mem_we    = 1'b0;
      mem_waddr = 8'd0;
      mem_wdata = 8'd0;
      finish    = 1'b0;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (bus.req) begin
               state_d = ST_RUN;
               ack_d   = 1'b0;
               idx_d   = 5'd0;
               phase_d = 1'b0;
               pat_d   = rd0[4:0];
               ctb_d   = 8'd0;
               cto_d   = 8'd0;
               cts_d   = 8'd0;
            end
         end
         ST_RUN: begin
            case (prog_q)
               2'd1, 2'd2: begin
                  mem_we  = 1'b1;
                  phase_d = ~phase_q;
                  if (!phase_q) begin
                     mem_waddr = ((prog_q == 2'd1) ? 8'd30 : 8'd94) + word_base;
                     mem_wdata = (prog_q == 2'd1) ? enc_w[7:0] : dec_w[7:0];
                  end else begin
                     mem_waddr = ((prog_q == 2'd1) ? 8'd31 : 8'd95) + word_base;
                     mem_wdata = (prog_q == 2'd1) ? enc_w[15:8]
                                                  : {dec_w[11], 4'b0000, dec_w[10:8]};
                     if (idx_q == 5'd14) finish = 1'b1;
                     else                idx_d  = idx_q + 5'd1;
                  end
               end
               2'd3: begin
                  if (!phase_q) begin
                     ctb_d = ctb_q + {5'b00000, nb};
                     cto_d = cto_q + {7'b0000000, (nb != 3'd0)};
                     cts_d = cts_q + {5'b00000, nb} + {5'b00000, nx};
                     if (idx_q == 5'd31) begin
                        phase_d = 1'b1;
                        idx_d   = 5'd0;
                     end else begin
                        idx_d = idx_q + 5'd1;
                     end
                  end else begin
                     mem_we    = 1'b1;
                     mem_waddr = 8'd192 + {3'b000, idx_q};
                     case (idx_q)
                        5'd0:    mem_wdata = ctb_q;
                        5'd1:    mem_wdata = cto_q;
                        default: mem_wdata = cts_q;
                     endcase
                     if (idx_q == 5'd2) finish = 1'b1;
                     else               idx_d  = idx_q + 5'd1;
                  end
               end
               default: state_d = ST_IDLE;
            endcase
         end
         default: state_d = ST_IDLE;
      endcase

      if (finish) begin
         state_d = ST_DONE;
         ack_d   = 1'b1;
         prog_d  = (prog_q == 2'd3) ? 2'd1 : prog_q + 2'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         prog_q  <= 2'd1;
         idx_q   <= 5'd0;
         phase_q <= 1'b0;
         ack_q   <= 1'b0;
         pat_q   <= 5'd0;
         ctb_q   <= 8'd0;
         cto_q   <= 8'd0;
         cts_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         prog_q  <= prog_d;
         idx_q   <= idx_d;
         phase_q <= phase_d;
         ack_q   <= ack_d;
         pat_q   <= pat_d;
         ctb_q   <= ctb_d;
         cto_q   <= cto_d;
         cts_q   <= cts_d;
      end
   end
endmodule

// File: tb/tb_top_level.sv
// Directed bench for top_level: table vectors per program plus sequencing and
// mid-program reset sequences, with memory preloaded and inspected hierarchically.
module tb_top_level;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   top_level_if bus ();
   top_level dut (.clk(clk), .reset(reset), .bus(bus));

   int n_vec = 0;
   int n_bad = 0;

   typedef struct {
      logic [15:0] in;
      logic [15:0] exp;
   } vec_t;

   typedef struct {
      logic [4:0] pat;
      logic [7:0] fill;
      logic [7:0] ctb;
      logic [7:0] cto;
      logic [7:0] cts;
   } p3_t;

   vec_t p1_tab [15];
   vec_t p2_tab [15];
   p3_t  p3_tab [4];

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   // Generic positional Hamming: data fills non-power-of-two positions in order.
   function automatic logic [15:0] enc_model(input logic [10:0] d);
      logic [15:0] w;
      logic        p;
      int          k;
      w = '0;
      k = 0;
      for (int pos = 1; pos < 16; pos++) begin
         if ((pos & (pos - 1)) != 0) begin
            w[pos] = d[k];
            k++;
         end
      end
      for (int b = 0; b < 4; b++) begin
         p = 1'b0;
         for (int pos = 1; pos < 16; pos++) begin
            if (((pos >> b) & 1) == 1 && pos != (1 << b)) p = p ^ w[pos];
         end
         w[1 << b] = p;
      end
      w[0] = ^w[15:1];
      return w;
   endfunction

   task automatic fill_mem(input int base, input int n, input logic [7:0] v);
      for (int a = base; a < base + n; a++) dut.data_mem1.core[a] = v;
   endtask

   task automatic run_prog(input string nm, input int limit);
      int cnt;
      @(negedge clk) bus.req = 1'b1;
      @(negedge clk) bus.req = 1'b0;
      chk({nm, "_ack_drop"}, 16'(bus.ack), 16'h0);
      cnt = 0;
      while (bus.ack !== 1'b1 && cnt < 100) begin
         @(negedge clk);
         cnt++;
      end
      chk({nm, "_done_in_time"}, 16'(bus.ack === 1'b1 && cnt <= limit), 16'h1);
   endtask

   task automatic check_p1(input string nm);
      for (int i = 0; i < 15; i++)
         chk($sformatf("%s_w%0d", nm, i),
             {dut.data_mem1.core[31 + 2*i], dut.data_mem1.core[30 + 2*i]}, p1_tab[i].exp);
   endtask

   task automatic check_p2(input string nm);
      for (int i = 0; i < 15; i++)
         chk($sformatf("%s_w%0d", nm, i),
             {dut.data_mem1.core[95 + 2*i], dut.data_mem1.core[94 + 2*i]}, p2_tab[i].exp);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [10:0] rd;
      bus.req = 1'b0;
      reset   = 1'b0;

      // Encoder vectors: {junk[4:0], d[11:1]} -> codeword.
      p1_tab[0] = '{in: {5'h15, 11'h000}, exp: 16'h0000};
      p1_tab[1] = '{in: {5'h0A, 11'h7FF}, exp: 16'hFFFF};
      p1_tab[2] = '{in: {5'h1F, 11'h001}, exp: 16'h000F};
      p1_tab[3] = '{in: {5'h03, 11'h400}, exp: 16'h8117};
      p1_tab[4] = '{in: {5'h11, 11'h010}, exp: 16'h0303};
      for (int i = 5; i < 15; i++) begin
         rd = 11'($urandom_range(0, 2047));
         p1_tab[i] = '{in: {5'(i), rd}, exp: enc_model(rd)};
      end

      // Decoder vectors: received word -> {hi byte, lo byte}.
      p2_tab[0]  = '{in: 16'hFFDF, exp: 16'h07FF};
      p2_tab[1]  = '{in: 16'hFFFE, exp: 16'h07FF};
      p2_tab[2]  = '{in: 16'h8000, exp: 16'h0000};
      p2_tab[3]  = '{in: 16'hFFD7, exp: 16'h87FC};
      p2_tab[4]  = '{in: 16'hFFFF, exp: 16'h07FF};
      p2_tab[5]  = '{in: 16'h0000, exp: 16'h0000};
      p2_tab[6]  = '{in: 16'h8117, exp: 16'h0400};
      p2_tab[7]  = '{in: 16'h8317, exp: 16'h0400};
      p2_tab[8]  = '{in: 16'h0302, exp: 16'h0010};
      p2_tab[9]  = '{in: 16'h0009, exp: 16'h8001};
      p2_tab[10] = '{in: 16'h0007, exp: 16'h0001};
      p2_tab[11] = '{in: 16'h7FFF, exp: 16'h07FF};
      p2_tab[12] = '{in: 16'h0001, exp: 16'h0000};
      p2_tab[13] = '{in: 16'h0303, exp: 16'h0010};
      p2_tab[14] = '{in: 16'hFFF3, exp: 16'h87FE};

      // Pattern cases; the last one only matches across the B5/B6 boundary.
      p3_tab[0] = '{pat: 5'b00000, fill: 8'h00, ctb: 8'd128, cto: 8'd32, cts: 8'd252};
      p3_tab[1] = '{pat: 5'b10101, fill: 8'h55, ctb: 8'd64,  cto: 8'd32, cts: 8'd126};
      p3_tab[2] = '{pat: 5'b11111, fill: 8'h00, ctb: 8'd0,   cto: 8'd0,  cts: 8'd0};
      p3_tab[3] = '{pat: 5'b11000, fill: 8'h00, ctb: 8'd0,   cto: 8'd0,  cts: 8'd1};

      repeat (3) @(negedge clk);
      chk("reset_ack", 16'(bus.ack), 16'h0);
      reset = 1'b1;

      for (int i = 0; i < 15; i++) begin
         dut.data_mem1.core[2*i]      = p1_tab[i].in[7:0];
         dut.data_mem1.core[2*i + 1]  = p1_tab[i].in[15:8];
         dut.data_mem1.core[64 + 2*i] = p2_tab[i].in[7:0];
         dut.data_mem1.core[65 + 2*i] = p2_tab[i].in[15:8];
      end

      for (int r = 0; r < 4; r++) begin
         fill_mem(30, 30, 8'hA5);
         run_prog($sformatf("p1_r%0d", r), 64);
         check_p1($sformatf("p1_r%0d", r));

         fill_mem(94, 30, 8'hA5);
         run_prog($sformatf("p2_r%0d", r), 64);
         check_p2($sformatf("p2_r%0d", r));

         fill_mem(128, 32, p3_tab[r].fill);
         dut.data_mem1.core[160] = {3'b111, p3_tab[r].pat};
         if (r == 3) begin
            dut.data_mem1.core[133] = 8'h01;
            dut.data_mem1.core[134] = 8'h80;
         end
         fill_mem(192, 3, 8'hA5);
         run_prog($sformatf("p3_r%0d", r), 40);
         chk($sformatf("p3_r%0d_ctb", r), 16'(dut.data_mem1.core[192]), 16'(p3_tab[r].ctb));
         chk($sformatf("p3_r%0d_cto", r), 16'(dut.data_mem1.core[193]), 16'(p3_tab[r].cto));
         chk($sformatf("p3_r%0d_cts", r), 16'(dut.data_mem1.core[194]), 16'(p3_tab[r].cts));
      end

      // Run program 1, then abort program 2 partway through with reset.
      run_prog("p1_pre_abort", 64);
      fill_mem(94, 30, 8'h00);
      @(negedge clk) bus.req = 1'b1;
      @(negedge clk) bus.req = 1'b0;
      chk("abort_ack_drop", 16'(bus.ack), 16'h0);
      repeat (6) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      chk("abort_ack_low", 16'(bus.ack), 16'h0);
      chk("abort_partial_kept", 16'(dut.data_mem1.core[94]), 16'h00FF);
      chk("abort_tail_untouched", {dut.data_mem1.core[123], dut.data_mem1.core[122]}, 16'h0000);
      chk("abort_p1_survives", {dut.data_mem1.core[31], dut.data_mem1.core[30]}, p1_tab[0].exp);
      repeat (3) @(negedge clk);
      chk("abort_stays_idle", 16'(bus.ack), 16'h0);

      fill_mem(30, 30, 8'hA5);
      run_prog("p1_after_reset", 64);
      check_p1("p1_after_reset");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
